// File: rtl/mips_cache_pkg.sv
// Shared cache package: write-buffer state encoding, entry layout and byte-merge helper.
package mips_cache_pkg;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_ISSUE = 2'd1
  } wbuf_state_t;

  typedef struct packed {
    logic        valid;
    logic [29:0] word_addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wbuf_entry_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_data,
                                              input logic [31:0] new_data,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_data;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mips_cache_wbuf_merge.sv
// Merging store buffer: circular FIFO of word entries, merges stores into queued words,
// drains one Avalon write at a time while granted, and flags read-after-write hazards.
module mips_cache_wbuf_merge
  import mips_cache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_advance,
  input  logic [31:0] addr,
  input  logic        write_en,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  input  logic        active,
  input  logic        waitrequest,
  input  logic [31:0] lookup_addr,
  output logic [31:0] write_addr,
  output logic [31:0] write_data,
  output logic [3:0]  write_byteenable,
  output logic        write_writeenable,
  output logic        lookup_hit,
  output logic        full,
  output logic        empty,
  output logic [1:0]  state_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbuf_entry_t      ent_q [DEPTH];
  wbuf_entry_t      ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  wbuf_state_t      state_q, state_d;

  logic             merge_hit;
  logic [PTR_W-1:0] merge_idx;
  logic             accept, do_merge, do_push, do_pop;
  logic             unused_lsbs;

  assign unused_lsbs = ^{addr[1:0], lookup_addr[1:0]};

  // The head entry is on the bus while in ISSUE and must never absorb a new store.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && ent_q[i].word_addr == addr[31:2] &&
          !(state_q == WB_ISSUE && PTR_W'(i) == head_q)) begin
        merge_hit = 1'b1;
        merge_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    lookup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && ent_q[i].word_addr == lookup_addr[31:2]) lookup_hit = 1'b1;
    end
  end

  assign accept   = write_en && cpu_advance;
  assign do_merge = accept && merge_hit;
  assign do_push  = accept && !merge_hit && !full_q;
  assign do_pop   = (state_q == WB_ISSUE) && !waitrequest;

  always_comb begin
    ent_d = ent_q;
    if (do_merge) begin
      ent_d[merge_idx].data = merge_bytes(ent_q[merge_idx].data, writedata, byteenable);
      ent_d[merge_idx].be   = ent_q[merge_idx].be | byteenable;
    end
    if (do_push) begin
      ent_d[tail_q].valid     = 1'b1;
      ent_d[tail_q].word_addr = addr[31:2];
      ent_d[tail_q].data      = writedata;
      ent_d[tail_q].be        = byteenable;
    end
    if (do_pop) ent_d[head_q].valid = 1'b0;
    head_d  = head_q + PTR_W'(do_pop);
    tail_d  = tail_q + PTR_W'(do_push);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_comb begin
    state_d           = state_q;
    write_writeenable = 1'b0;
    case (state_q)
      WB_IDLE: begin
        if (active && !empty_q) state_d = WB_ISSUE;
      end
      WB_ISSUE: begin
        write_writeenable = 1'b1;
        if (!waitrequest) begin
          state_d = (active && count_q > CNT_W'(1)) ? WB_ISSUE : WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      state_q <= WB_IDLE;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
      state_q <= state_d;
    end
  end

  // Head entry is stable during ISSUE because merges skip it.
  assign write_addr       = {ent_q[head_q].word_addr, 2'b00};
  assign write_data       = ent_q[head_q].data;
  assign write_byteenable = ent_q[head_q].be;
  assign full             = full_q;
  assign empty            = empty_q;
  assign state_out        = state_q;

endmodule
